conv_addr_seq: RTL and testbench

CONV_ADDR_SEQ -- requirements
Module: conv_addr_seq

---
 rtl/conv_addr_seq.sv | 148 ++++++++++++++
 tb/tb_conv_addr_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_seq.sv
// Segment-table address sequencer: walks a table of (base, len) segments and
// issues scratch-pad read addresses. Optional repeat passes: CONV_ADDR_SEQ_LOOP_EN.
module conv_addr_seq #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 4,
  parameter int NSEG   = 16,
  localparam int SEG_W = $clog2(NSEG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [SEG_W:0]    cfg_nseg,
`ifdef CONV_ADDR_SEQ_LOOP_EN
  input  logic [3:0]        cfg_rep,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic [SEG_W-1:0]  seg,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [SEG_W:0] NSEG_V = (SEG_W+1)'(NSEG);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base [NSEG];
  logic [LEN_W-1:0]  r_len  [NSEG];
  logic [ADDR_W-1:0] r_addr;
  logic [SEG_W-1:0]  r_seg;
  logic [SEG_W-1:0]  r_last;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
`ifdef CONV_ADDR_SEQ_LOOP_EN
  logic [3:0]        r_rep;
`endif

  logic              w_nseg_ok;
  logic [SEG_W:0]    w_nm1;
  logic              w_idx_ok;
  logic [ADDR_W-1:0] w_base0;
  logic              w_seg_end;
  logic              w_last_seg;
  logic [SEG_W-1:0]  w_seg_nx;
  logic              w_rep_more;

  assign w_nseg_ok  = (cfg_nseg != '0) && (cfg_nseg <= NSEG_V);
  assign w_nm1      = cfg_nseg - 1'b1;
  assign w_idx_ok   = ({1'b0, cfg_idx} < NSEG_V);
  // A write to entry 0 on the start cycle must already be seen by the first address.
  assign w_base0    = (cfg_we && (cfg_idx == '0)) ? cfg_base : r_base[0];
  assign w_seg_end  = (r_cnt == r_len[r_seg]);
  assign w_last_seg = (r_seg == r_last);
  assign w_seg_nx   = r_seg + 1'b1;
`ifdef CONV_ADDR_SEQ_LOOP_EN
  assign w_rep_more = (r_rep != '0);
`else
  assign w_rep_more = 1'b0;
`endif

  // Stall gates the strobe directly so a held address is never counted as issued.
  assign read = r_busy & ~hold;
  assign addr = r_addr;
  assign seg  = r_seg;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NSEG; i++) begin
        r_base[i] <= '0;
        r_len[i]  <= '0;
      end
      r_addr <= '0;
      r_seg  <= '0;
      r_last <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef CONV_ADDR_SEQ_LOOP_EN
      r_rep  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cfg_we && w_idx_ok) begin
            r_base[cfg_idx] <= cfg_base;
            r_len[cfg_idx]  <= cfg_len;
          end
          if (en && w_nseg_ok) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_addr  <= w_base0;
            r_seg   <= '0;
            r_cnt   <= '0;
            r_last  <= w_nm1[SEG_W-1:0];
`ifdef CONV_ADDR_SEQ_LOOP_EN
            r_rep   <= cfg_rep;
`endif
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (w_seg_end) begin
              r_cnt <= '0;
              if (!w_last_seg) begin
                r_seg  <= w_seg_nx;
                r_addr <= r_base[w_seg_nx];
              end else if (w_rep_more) begin
                r_seg  <= '0;
                r_addr <= r_base[0];
`ifdef CONV_ADDR_SEQ_LOOP_EN
                r_rep  <= r_rep - 1'b1;
`endif
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Self-checking bench for conv_addr_seq: expected read streams are built from a
// table model as flat lists of (address, segment) pairs.
module tb_conv_addr_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       hold;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [5:0] cfg_base;
  logic [3:0] cfg_len;
  logic [4:0] cfg_nseg;
`ifdef CONV_ADDR_SEQ_LOOP_EN
  logic [3:0] cfg_rep;
`endif
  logic [5:0] addr;
  logic       read;
  logic [3:0] seg;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int mbase [16];
  int mlen  [16];

  typedef struct { int a; int s; } ent_t;

  conv_addr_seq dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_nseg(cfg_nseg),
`ifdef CONV_ADDR_SEQ_LOOP_EN
    .cfg_rep(cfg_rep),
`endif
    .addr(addr), .read(read), .seg(seg), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mbase[i] = 0;
      mlen[i]  = 0;
    end
  endtask

  task automatic wr(input int i, input int b, input int l);
    @(posedge clk); #1;
    en = 1'b0; hold = 1'b0; cfg_we = 1'b1;
    cfg_idx = 4'(i); cfg_base = 6'(b); cfg_len = 4'(l);
    mbase[i] = b % 64;
    mlen[i]  = l % 16;
  endtask

  // noise: 0 quiet, 1 random en / table writes while busy, 2 write base 33 to entry 0 while busy
  task automatic run_seq(input int n, input int hmode, input int noise,
                         input bit wst, input int widx, input int wb, input int wl,
                         input int rep);
    ent_t q[$];
    ent_t e;
    int   hcnt;
    int   cyc;
    int   reps;
    bit   h;
    hcnt = 0;
    cyc  = 0;
    @(posedge clk); #1;
    en = 1'b1; hold = 1'b0; cfg_we = 1'b0; cfg_nseg = 5'(n);
`ifdef CONV_ADDR_SEQ_LOOP_EN
    cfg_rep = 4'(rep);
    reps = rep;
`else
    reps = 0;
`endif
    if (wst) begin
      cfg_we = 1'b1; cfg_idx = 4'(widx); cfg_base = 6'(wb); cfg_len = 4'(wl);
      mbase[widx] = wb % 64;
      mlen[widx]  = wl % 16;
    end
    if (n >= 1 && n <= 16) begin
      for (int p = 0; p <= reps; p++)
        for (int s = 0; s < n; s++)
          for (int k = 0; k <= mlen[s]; k++) begin
            e.a = (mbase[s] + k) % 64;
            e.s = s;
            q.push_back(e);
          end
    end
    @(negedge clk);
    chk("start_busy", busy, 0);
    chk("start_read", read, 0);
    if (q.size() == 0) begin
      repeat (3) begin
        @(posedge clk); #1;
        en = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        chk("ignored_busy", busy, 0);
        chk("ignored_read", read, 0);
        chk("ignored_done", done, 0);
      end
      return;
    end
    while (q.size() > 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      en = 1'b0; cfg_we = 1'b0;
      if (noise == 1) begin
        en = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          cfg_we = 1'b1; cfg_idx = 4'($urandom); cfg_base = 6'($urandom); cfg_len = 4'($urandom);
        end
      end else if (noise == 2) begin
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_base = 6'd33; cfg_len = 4'd2;
      end
      h = 1'b0;
      if (hmode == 1) h = ($urandom_range(0, 3) == 0);
      else if (hmode == 2 && q[0].a == 16 && hcnt < 3) begin
        h = 1'b1;
        hcnt++;
      end
      hold = h;
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_read", read, {31'd0, !h});
      chk("run_addr", addr, q[0].a);
      chk("run_seg", seg, q[0].s);
      if (!h) void'(q.pop_front());
    end
    if (q.size() > 0) chk("run_timeout", q.size(), 0);
    @(posedge clk); #1;
    hold = 1'b0; en = 1'b0; cfg_we = 1'b0;
    if (noise == 1) en = 1'($urandom_range(0, 1));
    if (noise == 2) cfg_we = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_read", read, 0);
    @(posedge clk); #1;
    en = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_read", read, 0);
  endtask

  initial begin
    int tb_b[10];
    int tb_l[10];
    int n;
    tb_b = '{14, 55, 7, 52, 0, 49, 21, 28, 35, 42};
    tb_l = '{6, 4, 6, 4, 6, 4, 8, 8, 8, 8};
    rst = 1'b0; en = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_nseg = '0;
`ifdef CONV_ADDR_SEQ_LOOP_EN
    cfg_rep = '0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_read", read, 0);
    chk("rst_seg", seg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // Ten-segment table, uninterrupted
    for (int i = 0; i < 10; i++) wr(i, tb_b[i], tb_l[i]);
    run_seq(10, 0, 0, 1'b0, 0, 0, 0, 0);

    // Three-cycle hold while addr 16 is pending
    run_seq(1, 2, 0, 1'b0, 0, 0, 0, 0);

    // Writes while busy are dropped; illegal segment counts are ignored
    run_seq(1, 0, 2, 1'b0, 0, 0, 0, 0);
    run_seq(1, 0, 0, 1'b0, 0, 0, 0, 0);
    run_seq(0, 0, 0, 1'b0, 0, 0, 0, 0);
    run_seq(17, 0, 0, 1'b0, 0, 0, 0, 0);

    // Reset in the middle of a run, at addr 55
    @(posedge clk); #1;
    en = 1'b1; cfg_we = 1'b0; hold = 1'b0; cfg_nseg = 5'd10;
`ifdef CONV_ADDR_SEQ_LOOP_EN
    cfg_rep = '0;
`endif
    @(posedge clk); #1;
    en = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_addr", addr, 55);
    chk("mid_read", read, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_read", read, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_seg", seg, 0);
    rst = 1'b1;
    clear_model();
    run_seq(3, 0, 0, 1'b0, 0, 0, 0, 0);

    // Write and start on the same cycle
    wr(1, 60, 1);
    run_seq(2, 0, 0, 1'b1, 0, 40, 2, 0);
    run_seq(2, 0, 0, 1'b1, 1, 9, 3, 0);

    // Address wrap
    wr(0, 62, 3);
    run_seq(1, 0, 0, 1'b0, 0, 0, 0, 0);

`ifdef CONV_ADDR_SEQ_LOOP_EN
    wr(0, 5, 1);
    run_seq(1, 0, 0, 1'b0, 0, 0, 0, 1);
`endif

    // Randomised tables, lengths, holds and noise
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
      n = int'($urandom_range(1, 16));
      run_seq(n, 1, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
